mitm_bus_ctrl: RTL and testbench

MITM_BUS_CTRL -- requirements
Module: mitm_bus_ctrl

---
 rtl/mitm_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mitm_bus_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mitm_bus_ctrl.sv
// Man-in-the-middle SPI bus controller: forwards MOSI/MISO between master and EEPROM,
// captures chunk bits on synchronized SCK rises and substitutes fake bits per chunk on demand.
module mitm_bus_ctrl #(
   parameter int BUF_SIZE         = 9,
   parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic                        bus_cs,
   input  logic                        bus_sck,
   input  logic                        bus_mosi_in,
   input  logic                        bus_miso_in,
   output logic                        bus_mosi_out,
   output logic                        bus_miso_out,
   input  logic                        cmd_next_chunk,
   input  logic                        cmd_finish,
   input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
   input  logic                        fake_mosi_select,
   input  logic                        fake_miso_select,
   input  logic [BUF_SIZE-1:0]         fake_mosi_data,
   input  logic [BUF_SIZE-1:0]         fake_miso_data,
   output logic                        comm_active,
   output logic                        bus_ready,
   output logic [BUF_SIZE-1:0]         real_mosi_data,
   output logic [BUF_SIZE-1:0]         real_miso_data
);

   // state    | meaning
   // IDLE     | CS low, no transaction
   // WAIT_CMD | CS high, waiting for next-chunk or finish command
   // SHIFT    | capturing a chunk, optionally substituting fake bits
   // PASS     | transparent forwarding until CS falls
   typedef enum logic [1:0] {IDLE, WAIT_CMD, SHIFT, PASS} state_t;

   localparam logic [CHUNK_SIZE_WIDTH-1:0] SIZE_MAX = CHUNK_SIZE_WIDTH'(BUF_SIZE);
   localparam logic [CHUNK_SIZE_WIDTH-1:0] ONE      = CHUNK_SIZE_WIDTH'(1);

   state_t state_q, state_d;
   logic cs_meta_q, cs_sync_q, cs_prev_q;
   logic sck_meta_q, sck_sync_q, sck_prev_q;
   logic mosi_meta_q, mosi_sync_q;
   logic miso_meta_q, miso_sync_q;
   logic [CHUNK_SIZE_WIDTH-1:0] cnt_q, cnt_d, size_q, size_d, idx_q, idx_d;
   logic sel_mosi_q, sel_mosi_d, sel_miso_q, sel_miso_d;
   logic [BUF_SIZE-1:0] fake_mosi_q, fake_mosi_d, fake_miso_q, fake_miso_d;
   logic [BUF_SIZE-1:0] shift_mosi_q, shift_mosi_d, shift_miso_q, shift_miso_d;
   logic [BUF_SIZE-1:0] real_mosi_q, real_mosi_d, real_miso_q, real_miso_d;
   logic [CHUNK_SIZE_WIDTH-1:0] size_clamped;
   logic cs_rise, cs_fall, sck_rise, sck_fall;

   assign cs_rise  = cs_sync_q & ~cs_prev_q;
   assign cs_fall  = ~cs_sync_q & cs_prev_q;
   assign sck_rise = sck_sync_q & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q & sck_prev_q;
   assign size_clamped = (next_chunk_size > SIZE_MAX) ? SIZE_MAX : next_chunk_size;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      size_d       = size_q;
      idx_d        = idx_q;
      sel_mosi_d   = sel_mosi_q;
      sel_miso_d   = sel_miso_q;
      fake_mosi_d  = fake_mosi_q;
      fake_miso_d  = fake_miso_q;
      shift_mosi_d = shift_mosi_q;
      shift_miso_d = shift_miso_q;
      real_mosi_d  = real_mosi_q;
      real_miso_d  = real_miso_q;
      case (state_q)
         IDLE: begin
            if (cs_rise) state_d = WAIT_CMD;
         end
         WAIT_CMD: begin
            if (cs_fall) begin
               state_d    = IDLE;
               sel_mosi_d = 1'b0;
               sel_miso_d = 1'b0;
            end else if (cmd_finish) begin
               state_d = PASS;
            end else if (cmd_next_chunk) begin
               state_d      = SHIFT;
               size_d       = size_clamped;
               idx_d        = (size_clamped == '0) ? '0 : size_clamped - ONE;
               cnt_d        = '0;
               sel_mosi_d   = fake_mosi_select;
               sel_miso_d   = fake_miso_select;
               fake_mosi_d  = fake_mosi_data;
               fake_miso_d  = fake_miso_data;
               shift_mosi_d = '0;
               shift_miso_d = '0;
            end
         end
         SHIFT: begin
            if (cs_fall) begin
               state_d    = IDLE;
               sel_mosi_d = 1'b0;
               sel_miso_d = 1'b0;
            end else if (cnt_q == size_q) begin
               // shift registers start cleared, so upper bits are already zero
               state_d = WAIT_CMD;
               if (size_q != '0) begin
                  real_mosi_d = shift_mosi_q;
                  real_miso_d = shift_miso_q;
               end
            end else begin
               if (sck_rise) begin
                  shift_mosi_d = {shift_mosi_q[BUF_SIZE-2:0], mosi_sync_q};
                  shift_miso_d = {shift_miso_q[BUF_SIZE-2:0], miso_sync_q};
                  cnt_d        = cnt_q + ONE;
               end
               if (sck_fall && idx_q != '0) idx_d = idx_q - ONE;
            end
         end
         PASS: begin
            if (cs_fall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cs_meta_q    <= 1'b0;
         cs_sync_q    <= 1'b0;
         cs_prev_q    <= 1'b0;
         sck_meta_q   <= 1'b0;
         sck_sync_q   <= 1'b0;
         sck_prev_q   <= 1'b0;
         mosi_meta_q  <= 1'b0;
         mosi_sync_q  <= 1'b0;
         miso_meta_q  <= 1'b0;
         miso_sync_q  <= 1'b0;
         cnt_q        <= '0;
         size_q       <= '0;
         idx_q        <= '0;
         sel_mosi_q   <= 1'b0;
         sel_miso_q   <= 1'b0;
         fake_mosi_q  <= '0;
         fake_miso_q  <= '0;
         shift_mosi_q <= '0;
         shift_miso_q <= '0;
         real_mosi_q  <= '0;
         real_miso_q  <= '0;
      end else begin
         state_q      <= state_d;
         cs_meta_q    <= bus_cs;
         cs_sync_q    <= cs_meta_q;
         cs_prev_q    <= cs_sync_q;
         sck_meta_q   <= bus_sck;
         sck_sync_q   <= sck_meta_q;
         sck_prev_q   <= sck_sync_q;
         mosi_meta_q  <= bus_mosi_in;
         mosi_sync_q  <= mosi_meta_q;
         miso_meta_q  <= bus_miso_in;
         miso_sync_q  <= miso_meta_q;
         cnt_q        <= cnt_d;
         size_q       <= size_d;
         idx_q        <= idx_d;
         sel_mosi_q   <= sel_mosi_d;
         sel_miso_q   <= sel_miso_d;
         fake_mosi_q  <= fake_mosi_d;
         fake_miso_q  <= fake_miso_d;
         shift_mosi_q <= shift_mosi_d;
         shift_miso_q <= shift_miso_d;
         real_mosi_q  <= real_mosi_d;
         real_miso_q  <= real_miso_d;
      end
   end

   assign comm_active    = (state_q != IDLE);
   assign bus_ready      = (state_q == IDLE) || (state_q == WAIT_CMD);
   assign real_mosi_data = real_mosi_q;
   assign real_miso_data = real_miso_q;
   // substitution uses the raw lines as fallback so passthrough adds no latency
   assign bus_mosi_out = (state_q == SHIFT && sel_mosi_q) ? fake_mosi_q[idx_q] : bus_mosi_in;
   assign bus_miso_out = (state_q == SHIFT && sel_miso_q) ? fake_miso_q[idx_q] : bus_miso_in;

endmodule

// File: tb/tb_mitm_bus_ctrl.sv
// Testbench for mitm_bus_ctrl: scenario tasks drive an SPI master/EEPROM model and
// compare captured chunks against a scoreboard queue of expected values.
module tb_mitm_bus_ctrl;

   logic       sys_clk = 1'b0;
   logic       rst, bus_cs, bus_sck, bus_mosi_in, bus_miso_in;
   logic       bus_mosi_out, bus_miso_out;
   logic       cmd_next_chunk, cmd_finish;
   logic [3:0] next_chunk_size;
   logic       fake_mosi_select, fake_miso_select;
   logic [8:0] fake_mosi_data, fake_miso_data;
   logic       comm_active, bus_ready;
   logic [8:0] real_mosi_data, real_miso_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [8:0] mosi;
      logic [8:0] miso;
   } exp_t;
   exp_t sb_q[$];
   exp_t e;
   logic [8:0] seen_mosi, seen_miso;
   bit ok;

   mitm_bus_ctrl dut (
      .sys_clk(sys_clk), .rst(rst), .bus_cs(bus_cs), .bus_sck(bus_sck),
      .bus_mosi_in(bus_mosi_in), .bus_miso_in(bus_miso_in),
      .bus_mosi_out(bus_mosi_out), .bus_miso_out(bus_miso_out),
      .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
      .next_chunk_size(next_chunk_size),
      .fake_mosi_select(fake_mosi_select), .fake_miso_select(fake_miso_select),
      .fake_mosi_data(fake_mosi_data), .fake_miso_data(fake_miso_data),
      .comm_active(comm_active), .bus_ready(bus_ready),
      .real_mosi_data(real_mosi_data), .real_miso_data(real_miso_data)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic cs_up();
      bus_cs = 1'b1;
      tick(4);
   endtask

   task automatic cmd_chunk(input logic [3:0] size, input logic sm, input logic smi,
                            input logic [8:0] fm, input logic [8:0] fmi);
      next_chunk_size  = size;
      fake_mosi_select = sm;
      fake_miso_select = smi;
      fake_mosi_data   = fm;
      fake_miso_data   = fmi;
      cmd_next_chunk   = 1'b1;
      tick(1);
      cmd_next_chunk   = 1'b0;
   endtask

   // SPI mode 0 master: data set while SCK low, lines observed just before each rise
   task automatic shift_bits(input int n, input logic [8:0] mosi_v, input logic [8:0] miso_v);
      seen_mosi = '0;
      seen_miso = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bus_mosi_in = mosi_v[i];
         bus_miso_in = miso_v[i];
         tick(6);
         seen_mosi = {seen_mosi[7:0], bus_mosi_out};
         seen_miso = {seen_miso[7:0], bus_miso_out};
         bus_sck = 1'b1;
         tick(6);
         bus_sck = 1'b0;
      end
      tick(6);
   endtask

   task automatic wait_ready(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus_cs = 0; bus_sck = 0; bus_mosi_in = 0; bus_miso_in = 0;
      cmd_next_chunk = 0; cmd_finish = 0; next_chunk_size = 0;
      fake_mosi_select = 0; fake_miso_select = 0; fake_mosi_data = 0; fake_miso_data = 0;
      tick(3);
      checks++;
      if (comm_active !== 1'b0 || bus_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: active=%b ready=%b, required 0 1", comm_active, bus_ready);
      end
      checks++;
      if (real_mosi_data !== 9'h0 || real_miso_data !== 9'h0) begin
         errors++;
         $display("FAIL reset_data: mosi=%h miso=%h, required 000 000", real_mosi_data, real_miso_data);
      end
      bus_mosi_in = 1; bus_miso_in = 1; #1;
      checks++;
      if (bus_mosi_out !== 1'b1 || bus_miso_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_passthru: mosi_out=%b miso_out=%b, required 1 1", bus_mosi_out, bus_miso_out);
      end
      bus_mosi_in = 0; bus_miso_in = 0;
      rst = 1'b0;
      tick(2);
      cmd_chunk(4'd3, 0, 0, 9'h0, 9'h0);
      tick(1);
      checks++;
      if (comm_active !== 1'b0 || bus_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_cmd_ignored: active=%b ready=%b, required 0 1", comm_active, bus_ready);
      end
   endtask

   task automatic test_passthrough_chunks();
      cs_up();
      checks++;
      if (comm_active !== 1'b1 || bus_ready !== 1'b1) begin
         errors++;
         $display("FAIL cs_rise: active=%b ready=%b, required 1 1", comm_active, bus_ready);
      end
      sb_q.push_back('{mosi: 9'h006, miso: 9'h003});
      cmd_chunk(4'd3, 0, 0, 9'h0, 9'h0);
      checks++;
      if (bus_ready !== 1'b0) begin
         errors++;
         $display("FAIL shift_busy: ready=%b, required 0", bus_ready);
      end
      shift_bits(3, 9'b110, 9'b011);
      checks++;
      if (seen_mosi !== 9'h006 || seen_miso !== 9'h003) begin
         errors++;
         $display("FAIL mirror3: mosi_out=%h miso_out=%h, required 006 003", seen_mosi, seen_miso);
      end
      wait_ready(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ready3: bus_ready=%b after budget, required 1", bus_ready);
      end
      e = sb_q.pop_front();
      checks++;
      if (real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL chunk3: mosi=%h miso=%h, required %h %h", real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
      sb_q.push_back('{mosi: 9'h14a, miso: 9'h0f0});
      cmd_chunk(4'd9, 0, 0, 9'h0, 9'h0);
      shift_bits(9, 9'h14a, 9'h0f0);
      wait_ready(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL chunk9: ready=%b mosi=%h miso=%h, required 1 %h %h", bus_ready, real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
      cmd_finish = 1'b1; tick(1); cmd_finish = 1'b0;
      bus_mosi_in = 1; bus_miso_in = 0; #1;
      checks++;
      if (bus_ready !== 1'b0 || comm_active !== 1'b1 || bus_mosi_out !== 1'b1 || bus_miso_out !== 1'b0) begin
         errors++;
         $display("FAIL pass_state: ready=%b active=%b mo=%b mi=%b, required 0 1 1 0", bus_ready, comm_active, bus_mosi_out, bus_miso_out);
      end
      bus_cs = 1'b0;
      tick(4);
      checks++;
      if (comm_active !== 1'b0 || bus_ready !== 1'b1) begin
         errors++;
         $display("FAIL pass_exit: active=%b ready=%b, required 0 1", comm_active, bus_ready);
      end
   endtask

   task automatic test_fake_miso();
      cs_up();
      sb_q.push_back('{mosi: 9'h03c, miso: 9'h000});
      cmd_chunk(4'd8, 0, 1, 9'h0, 9'h0aa);
      shift_bits(8, 9'h03c, 9'h000);
      checks++;
      if (seen_miso !== 9'h0aa || seen_mosi !== 9'h03c) begin
         errors++;
         $display("FAIL fake_miso_seen: miso_out=%h mosi_out=%h, required 0aa 03c", seen_miso, seen_mosi);
      end
      wait_ready(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL fake_miso_real: ready=%b mosi=%h miso=%h, required 1 %h %h", bus_ready, real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
   endtask

   task automatic test_both_cmds_and_clamp();
      next_chunk_size = 4'd3;
      cmd_next_chunk = 1'b1; cmd_finish = 1'b1;
      tick(1);
      cmd_next_chunk = 1'b0; cmd_finish = 1'b0;
      shift_bits(3, 9'b101, 9'b101);
      checks++;
      if (bus_ready !== 1'b0 || real_mosi_data !== 9'h03c || real_miso_data !== 9'h000) begin
         errors++;
         $display("FAIL finish_wins: ready=%b mosi=%h miso=%h, required 0 03c 000", bus_ready, real_mosi_data, real_miso_data);
      end
      bus_cs = 1'b0;
      tick(4);
      cs_up();
      sb_q.push_back('{mosi: 9'h1b5, miso: 9'h0cc});
      cmd_chunk(4'd12, 0, 0, 9'h0, 9'h0);
      shift_bits(9, 9'h1b5, 9'h0cc);
      wait_ready(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL clamp12: ready=%b mosi=%h miso=%h, required 1 %h %h", bus_ready, real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
   endtask

   task automatic test_size_zero();
      cmd_chunk(4'd0, 0, 0, 9'h0, 9'h0);
      checks++;
      if (bus_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_entry: ready=%b, required 0", bus_ready);
      end
      tick(1);
      checks++;
      if (bus_ready !== 1'b1 || real_mosi_data !== 9'h1b5 || real_miso_data !== 9'h0cc) begin
         errors++;
         $display("FAIL zero_done: ready=%b mosi=%h miso=%h, required 1 1b5 0cc", bus_ready, real_mosi_data, real_miso_data);
      end
   endtask

   task automatic test_back_to_back();
      sb_q.push_back('{mosi: 9'h009, miso: 9'h006});
      sb_q.push_back('{mosi: 9'h016, miso: 9'h019});
      cmd_chunk(4'd4, 0, 0, 9'h0, 9'h0);
      shift_bits(4, 9'h009, 9'h006);
      wait_ready(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL b2b_first: ready=%b mosi=%h miso=%h, required 1 %h %h", bus_ready, real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
      cmd_chunk(4'd5, 1, 0, 9'h00c, 9'h0);
      shift_bits(5, 9'h016, 9'h019);
      checks++;
      if (seen_mosi !== 9'h00c || seen_miso !== 9'h019) begin
         errors++;
         $display("FAIL b2b_fake_mosi: mosi_out=%h miso_out=%h, required 00c 019", seen_mosi, seen_miso);
      end
      wait_ready(ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || real_mosi_data !== e.mosi || real_miso_data !== e.miso) begin
         errors++;
         $display("FAIL b2b_second: ready=%b mosi=%h miso=%h, required 1 %h %h", bus_ready, real_mosi_data, real_miso_data, e.mosi, e.miso);
      end
   endtask

   task automatic test_abort();
      cmd_chunk(4'd3, 1, 0, 9'b010, 9'h0);
      shift_bits(2, 9'b11, 9'b11);
      checks++;
      if (seen_mosi !== 9'b01) begin
         errors++;
         $display("FAIL abort_fake_bits: mosi_out=%h, required 001", seen_mosi);
      end
      bus_cs = 1'b0;
      tick(4);
      bus_mosi_in = 1; bus_miso_in = 1; #1;
      checks++;
      if (comm_active !== 1'b0 || bus_ready !== 1'b1 || real_mosi_data !== 9'h016 ||
          real_miso_data !== 9'h019 || bus_mosi_out !== 1'b1 || bus_miso_out !== 1'b1) begin
         errors++;
         $display("FAIL abort: active=%b ready=%b mosi=%h miso=%h mo=%b mi=%b, required 0 1 016 019 1 1",
                  comm_active, bus_ready, real_mosi_data, real_miso_data, bus_mosi_out, bus_miso_out);
      end
   endtask

   task automatic test_reset_mid_shift();
      cs_up();
      cmd_chunk(4'd5, 1, 1, 9'h015, 9'h00a);
      shift_bits(2, 9'b11, 9'b11);
      rst = 1'b1;
      bus_mosi_in = 0; bus_miso_in = 1;
      tick(1);
      checks++;
      if (comm_active !== 1'b0 || bus_ready !== 1'b1 || real_mosi_data !== 9'h0 ||
          real_miso_data !== 9'h0 || bus_mosi_out !== 1'b0 || bus_miso_out !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_shift: active=%b ready=%b mosi=%h miso=%h mo=%b mi=%b, required 0 1 000 000 0 1",
                  comm_active, bus_ready, real_mosi_data, real_miso_data, bus_mosi_out, bus_miso_out);
      end
      bus_cs = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(3);
   endtask

   initial begin
      test_reset();
      test_passthrough_chunks();
      test_fake_miso();
      test_both_cmds_and_clamp();
      test_size_zero();
      test_back_to_back();
      test_abort();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
